// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 write sequencer: FSM states,
// bit positions inside the core LCD word and the power-up init ROM.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PWRUP,
    ST_ILOAD,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_EXEC
  } lcd_state_e;

  localparam int LCD_ON_BIT = 31;
  localparam int LCD_GO_BIT = 10;
  localparam int LCD_RS_BIT = 9;

  localparam int INIT_LEN = 4;
  localparam logic [7:0] INIT_ROM [INIT_LEN] = '{8'h38, 8'h0C, 8'h01, 8'h06};

  function automatic int unsigned umax(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Clear display (0x01) is the slow command that needs the long wait.
  function automatic logic is_clear(input logic rs, input logic [7:0] data);
    return (rs == 1'b0) && (data[7:1] == 7'd0) && (data != 8'd0);
  endfunction

endpackage

// File: rtl/lcd_write_sequencer.sv
// Turns one firmware write of {ON, GO, RS, DATA} into a timed HD44780 bus
// cycle, and runs the standard power-up init sequence after reset.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a GO rising edge, busy=0
// PWRUP | power-up delay after reset, all bus outputs 0
// ILOAD | zero-time step: next init ROM byte loaded on the way into SETUP
// SETUP | RS/DATA stable, EN low
// PULSE | EN high
// HOLD  | EN low, RS/DATA still held
// EXEC  | controller execution wait, then next init entry or IDLE
module lcd_write_sequencer
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYC = 4,
  parameter int unsigned EN_CYC    = 25,
  parameter int unsigned HOLD_CYC  = 4,
  parameter int unsigned EXEC_CYC  = 2000,
  parameter int unsigned CLEAR_CYC = 82000,
  parameter int unsigned PWRUP_CYC = 750000,
  parameter bit          INIT_EN   = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_io_lcd,
  output logic        o_lcd_on,
  output logic        o_lcd_en,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic [7:0]  o_lcd_data,
  output logic        o_busy,
  output logic        o_overrun
);

  localparam int unsigned MAX_CYC = umax(umax(umax(SETUP_CYC, EN_CYC), umax(HOLD_CYC, EXEC_CYC)),
                                         umax(CLEAR_CYC, PWRUP_CYC));
  localparam int TW = $clog2(MAX_CYC + 1);

  lcd_state_e     state, nxt;
  logic [TW-1:0]  tmr, tmr_load;
  logic           tmr_done;
  logic           go_prev, go_edge;
  logic [2:0]     init_idx;
  logic           ld_user, ld_rom;
  logic [7:0]     rom_byte;
  logic           unused_bits;

  assign unused_bits = ^{i_io_lcd[30:11], i_io_lcd[8]};

  assign go_edge  = i_io_lcd[LCD_GO_BIT] & ~go_prev;
  assign tmr_done = (tmr == TW'(1));
  assign rom_byte = INIT_ROM[init_idx[1:0]];
  assign o_lcd_rw = 1'b0;

  always_comb begin
    nxt     = state;
    ld_user = 1'b0;
    ld_rom  = 1'b0;
    case (state)
      ST_IDLE:  if (go_edge) begin
                  nxt     = ST_SETUP;
                  ld_user = 1'b1;
                end
      ST_PWRUP: if (tmr_done) nxt = ST_ILOAD;
      ST_SETUP: if (tmr_done) nxt = ST_PULSE;
      ST_PULSE: if (tmr_done) nxt = ST_HOLD;
      ST_HOLD:  if (tmr_done) nxt = ST_EXEC;
      ST_EXEC:  if (tmr_done) nxt = (init_idx < 3'(INIT_LEN)) ? ST_ILOAD : ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
    // ILOAD takes no cycle of its own: the ROM byte rides the entry into SETUP.
    if (nxt == ST_ILOAD) begin
      nxt    = ST_SETUP;
      ld_rom = 1'b1;
    end
  end

  always_comb begin
    tmr_load = '0;
    case (nxt)
      ST_PWRUP: tmr_load = TW'(PWRUP_CYC);
      ST_SETUP: tmr_load = TW'(SETUP_CYC);
      ST_PULSE: tmr_load = TW'(EN_CYC);
      ST_HOLD:  tmr_load = TW'(HOLD_CYC);
      ST_EXEC:  tmr_load = is_clear(o_lcd_rs, o_lcd_data) ? TW'(CLEAR_CYC) : TW'(EXEC_CYC);
      default:  tmr_load = '0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= INIT_EN ? ST_PWRUP : ST_IDLE;
      tmr        <= INIT_EN ? TW'(PWRUP_CYC) : '0;
      init_idx   <= INIT_EN ? 3'd0 : 3'(INIT_LEN);
      go_prev    <= 1'b1;
      o_lcd_on   <= 1'b0;
      o_lcd_en   <= 1'b0;
      o_lcd_rs   <= 1'b0;
      o_lcd_data <= 8'd0;
      o_busy     <= INIT_EN;
      o_overrun  <= 1'b0;
    end else begin
      state   <= nxt;
      go_prev <= i_io_lcd[LCD_GO_BIT];
      if (nxt != state)
        tmr <= tmr_load;
      else if (tmr != '0)
        tmr <= tmr - TW'(1);
      if (ld_user) begin
        o_lcd_rs   <= i_io_lcd[LCD_RS_BIT];
        o_lcd_data <= i_io_lcd[7:0];
      end else if (ld_rom) begin
        o_lcd_rs   <= 1'b0;
        o_lcd_data <= rom_byte;
        init_idx   <= init_idx + 3'd1;
      end
      o_lcd_en <= (nxt == ST_PULSE);
      o_busy   <= (nxt != ST_IDLE);
      o_lcd_on <= i_io_lcd[LCD_ON_BIT];
      if (go_edge && (state != ST_IDLE))
        o_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Bench for lcd_write_sequencer: a timeline model of init and user writes is
// compared every cycle, plus hand-computed checks of the headline timings.
module tb_lcd_write_sequencer;

  localparam int S = 2, E = 3, H = 2, X = 5, C = 20, P = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] io;
  logic        lcd_on, lcd_en, lcd_rs, lcd_rw, busy, overrun;
  logic [7:0]  lcd_data;

  always #5 clk = ~clk;

  lcd_write_sequencer #(
    .SETUP_CYC(S), .EN_CYC(E), .HOLD_CYC(H), .EXEC_CYC(X),
    .CLEAR_CYC(C), .PWRUP_CYC(P), .INIT_EN(1'b1)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_io_lcd(io),
    .o_lcd_on(lcd_on), .o_lcd_en(lcd_en), .o_lcd_rs(lcd_rs), .o_lcd_rw(lcd_rw),
    .o_lcd_data(lcd_data), .o_busy(busy), .o_overrun(overrun)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: power-up phase counts cycles; a transaction is a start edge plus
  // elapsed cycle count k, with EN high for k in [S, S+E) and busy while k < total.
  logic [7:0] rom [4];
  bit         m_pwr, m_txn, m_go_prev, m_on, m_ovr, m_rs;
  int         m_pwr_cnt, m_k, m_total, m_rom_idx;
  logic [7:0] m_data;

  task automatic m_start(input logic [7:0] d, input logic rs);
    m_txn   = 1'b1;
    m_k     = 0;
    m_data  = d;
    m_rs    = rs;
    m_total = S + E + H + ((rs == 1'b0 && d[7:1] == 7'd0 && d != 8'd0) ? C : X);
  endtask

  task automatic m_reset();
    m_pwr = 1'b1; m_pwr_cnt = 0; m_txn = 1'b0; m_k = 0; m_total = 0;
    m_rom_idx = 0; m_go_prev = 1'b1; m_on = 1'b0; m_ovr = 1'b0;
    m_rs = 1'b0; m_data = 8'd0;
  endtask

  task automatic m_step();
    bit go, go_edge, idle;
    go        = io[10];
    go_edge   = go && !m_go_prev;
    m_go_prev = go;
    idle      = !m_pwr && !m_txn;
    if (go_edge && !idle) m_ovr = 1'b1;
    m_on = io[31];
    if (m_pwr) begin
      m_pwr_cnt++;
      if (m_pwr_cnt == P) begin
        m_pwr = 1'b0;
        m_start(rom[0], 1'b0);
        m_rom_idx = 1;
      end
    end else if (m_txn) begin
      m_k++;
      if (m_k == m_total) begin
        m_txn = 1'b0;
        if (m_rom_idx < 4) begin
          m_start(rom[m_rom_idx], 1'b0);
          m_rom_idx++;
        end
      end
    end else if (go_edge) begin
      m_start(io[7:0], io[9]);
    end
  endtask

  initial begin
    rom[0] = 8'h38; rom[1] = 8'h0C; rom[2] = 8'h01; rom[3] = 8'h06;
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset();
      else m_step();
    end
  end

  // Per-cycle compare plus an EN pulse monitor.
  bit         chk_on = 1'b0;
  bit         en_d = 1'b0;
  int         en_len = 0, last_en_len = 0;
  logic [7:0] pulse_q[$];

  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        check("on",      lcd_on,   m_on);
        check("en",      lcd_en,   m_txn && m_k >= S && m_k < S + E);
        check("rw",      lcd_rw,   0);
        check("busy",    busy,     m_pwr || m_txn);
        check("overrun", overrun,  m_ovr);
        if (m_pwr || m_txn || m_k > 0) begin
          check("rs",   lcd_rs,   m_rs);
          check("data", lcd_data, m_data);
        end
      end
      if (lcd_en && !en_d) begin
        pulse_q.push_back(lcd_data);
        en_len = 0;
      end
      if (lcd_en) en_len++;
      if (!lcd_en && en_d) last_en_len = en_len;
      en_d = lcd_en;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic init_sequence_checks(input string tag);
    int cyc;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (busy && cyc < 300);
    check({tag, "_busy_len"}, cyc, 73);
    check({tag, "_pulses"}, pulse_q.size(), 4);
    if (pulse_q.size() == 4) begin
      check({tag, "_rom0"}, pulse_q[0], 8'h38);
      check({tag, "_rom1"}, pulse_q[1], 8'h0C);
      check({tag, "_rom2"}, pulse_q[2], 8'h01);
      check({tag, "_rom3"}, pulse_q[3], 8'h06);
    end
    check({tag, "_en_len"}, last_en_len, 3);
  endtask

  task automatic run_txn(input logic [31:0] w, output int blen, output int en_first);
    int cyc;
    io  = w;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!busy && cyc < 10);
    io       = w & ~32'h0000_0400;
    blen     = 0;
    en_first = -1;
    while (busy && blen < 200) begin
      if (lcd_en && en_first < 0) en_first = blen;
      blen++;
      tick();
    end
  endtask

  initial begin
    int blen, en_first, pc0, cyc;
    io  = 32'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    #1;
    check("rst_busy", busy, 1);
    check("rst_en", lcd_en, 0);
    check("rst_data", lcd_data, 0);
    check("rst_overrun", overrun, 0);
    pulse_q.delete();
    rst = 1'b0;

    // Power-up init sequence
    init_sequence_checks("init");

    // Data write with a second GO edge landing in EXEC
    pc0 = pulse_q.size();
    io  = 32'h8000_0641;
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!busy && cyc < 10);
    check("t2_busy_rise", busy, 1);
    blen = 0;
    en_first = -1;
    while (busy && blen < 100) begin
      if (lcd_en && en_first < 0) en_first = blen;
      case (blen)
        8:  io = 32'h8000_0041;
        9:  io = 32'h8000_0455;
        10: io = 32'h8000_0055;
        default: ;
      endcase
      blen++;
      tick();
    end
    check("t2_busy_len", blen, 12);
    check("t2_en_first", en_first, 2);
    check("t2_en_len", last_en_len, 3);
    check("t2_pulses", pulse_q.size(), pc0 + 1);
    check("t2_data", lcd_data, 8'h41);
    check("t2_rs", lcd_rs, 1);
    check("t2_on", lcd_on, 1);
    check("t4_overrun", overrun, 1);
    repeat (5) tick();
    check("t4_no_extra", pulse_q.size(), pc0 + 1);
    check("t4_data_kept", lcd_data, 8'h41);

    // Clear display uses the long wait
    pc0 = pulse_q.size();
    run_txn(32'h0000_0401, blen, en_first);
    check("t3_busy_len", blen, 27);
    check("t3_en_first", en_first, 2);
    check("t3_pulses", pulse_q.size(), pc0 + 1);
    check("t3_data", lcd_data, 8'h01);
    check("t3_rs", lcd_rs, 0);
    check("t3_on", lcd_on, 0);
    check("t4_overrun_sticky", overrun, 1);

    // Level-held GO issues one transaction; a fresh edge issues another
    pc0 = pulse_q.size();
    io  = 32'h0000_0423;
    repeat (50) tick();
    check("t5_one_pulse", pulse_q.size(), pc0 + 1);
    check("t5_idle", busy, 0);
    io = 32'h0000_0023;
    repeat (2) tick();
    io = 32'h0000_0423;
    repeat (20) tick();
    check("t5_second_pulse", pulse_q.size(), pc0 + 2);
    io = 32'd0;
    tick();

    // Reset in the middle of the EN pulse
    io  = 32'h8000_0477;
    cyc = 0;
    while (!lcd_en && cyc < 20) begin
      tick();
      cyc++;
    end
    check("t6_en_seen", lcd_en, 1);
    rst = 1'b1;
    #1;
    check("t6_en_drop", lcd_en, 0);
    check("t6_data_drop", lcd_data, 0);
    check("t6_busy", busy, 1);
    check("t6_overrun_clr", overrun, 0);
    repeat (2) tick();
    io = 32'd0;
    pulse_q.delete();
    rst = 1'b0;
    init_sequence_checks("t6");

    // Randomized traffic against the model, with one reset in the middle
    for (int i = 0; i < 3000; i++) begin
      int unsigned r;
      logic [31:0] w;
      r = $urandom_range(0, 99);
      w = io;
      if (r < 6) w[10] = ~w[10];
      if (!w[10] && r >= 10 && r < 40) begin
        w[9]     = 1'($urandom_range(0, 1));
        w[30:11] = 20'($urandom);
        w[8]     = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
          0:       w[7:0] = 8'h01;
          1:       w[7:0] = 8'h02;
          default: w[7:0] = 8'($urandom);
        endcase
      end
      if (r == 99) w[31] = ~w[31];
      if (i == 1500) rst = 1'b1;
      if (i == 1503) rst = 1'b0;
      io = w;
      tick();
    end
    io = 32'd0;
    cyc = 0;
    while (busy && cyc < 200) begin
      tick();
      cyc++;
    end
    check("final_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
